mix_columns_engine: RTL and testbench
=====================================

MIX_COLUMNS_ENGINE -- requirements
Module: mix_columns_engine

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1: columns transformed per RUN cycle; legal values 1, 2, 4; any other value is an elaboration error.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: in_state and in_inv are valid.
REQ-005 SHALL have port in_ready, output, 1 bit: engine accepts a block this cycle.
REQ-006 SHALL have port in_state, input, 128 bits: AES state; column c = bits [127-32c -: 32]; row 0 is the MSB byte of each column.
REQ-007 SHALL have port in_inv, input, 1 bit: 0 = MixColumns, 1 = InvMixColumns.
REQ-008 SHALL have port out_valid, output, 1 bit: out_state holds a finished block.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer takes the block.
REQ-010 SHALL have port out_state, output, 128 bits: transformed state, same byte layout as in_state.
REQ-011 SHALL have port busy, output, 1 bit: high in RUN or DONE.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 SHALL accept a block on the rising edge where in_valid and in_ready are both high, latching in_state, in_inv and col_idx=0, and entering RUN.
REQ-014 SHALL drive in_ready high in IDLE, high in DONE when out_ready is high, and low otherwise.
REQ-015 SHALL, in each RUN cycle, replace columns col_idx to col_idx+COLS_PER_CYCLE-1 of the working register with their transform and add COLS_PER_CYCLE to col_idx (2-bit, wraps to 0).
REQ-016 SHALL go RUN -> DONE on the cycle that processes the last column; the RUN phase lasts exactly 4/COLS_PER_CYCLE cycles.
REQ-017 SHALL keep out_valid high throughout DONE, with out_state equal to the working register and stable until a handshake.
REQ-018 SHALL, in DONE with out_ready high and in_valid low, go to IDLE.
REQ-019 SHALL, in DONE with out_ready and in_valid both high, accept the new block directly into RUN (back-to-back, no IDLE bubble).
REQ-020 SHALL, when out_ready is low in DONE, hold the state and ignore in_valid.
REQ-021 SHALL compute the forward column with matrix rows [02 03 01 01] rotated per row.
REQ-022 SHALL compute the inverse column with matrix rows [0e 0b 0d 09] rotated per row.
REQ-023 SHALL perform GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1, with xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 0); the multiply-by-02 stage is shared by both modes.
REQ-024 SHALL give the mode latched at acceptance priority over in_inv for the whole block; in_inv changes during RUN have no effect.
REQ-025 SHALL have an accept-to-out_valid latency of 4/COLS_PER_CYCLE cycles: 4, 2 or 1.
REQ-026 SHALL ignore in_state, in_inv and in_valid in RUN.

Reset
REQ-027 SHALL, while rst_n is low, force the FSM to IDLE, col_idx to 0, the working register to 0 and the mode to 0, regardless of clk.
REQ-028 SHALL drive out_valid=0, busy=0, out_state=128'h0 and in_ready=0 while in reset.
REQ-029 SHALL raise in_ready on the first clk edge after rst_n deasserts.
REQ-030 SHALL silently discard a block that is in flight in RUN or DONE when reset asserts; no partial result is presented.

Structure
REQ-031 SHALL place the following in a shared package mix_pkg: state/column/byte width constants, the polynomial 8'h1b, the FSM state enum, and an xtime function.
REQ-032 SHALL implement one column transform (32 bits in, 32 bits out, inv select) as sub-module mix_column_unit, combinational, instantiated COLS_PER_CYCLE times.
REQ-033 SHALL keep the datapath registers only at the working register; mix_column_unit SHALL contain no registers.

Verification
REQ-034 SHALL cover this scenario: COLS_PER_CYCLE=1, forward, all columns db135345 -> every column 8e4da1bc, out_valid exactly 4 cycles after accept.
REQ-035 SHALL cover this scenario: COLS_PER_CYCLE=4, inverse, columns 8e4da1bc, 9fdc589d, 01010101, d5d5d7d6 -> db135345, f20a225c, 01010101, d4d4d4d5, 1-cycle latency.
REQ-036 SHALL cover this scenario: COLS_PER_CYCLE=2, forward, c6c6c6c6 / 2d26314c / f20a225c / 01010101 -> c6c6c6c6 / 4d7ebdf8 / 9fdc589d / 01010101, then out_ready held low 5 cycles -> out_state stable and in_ready low.
REQ-037 SHALL cover this scenario: back-to-back, with in_valid and out_ready high in DONE -> the second block is accepted on the same edge, with no idle cycle between out_valid pulses.
REQ-038 SHALL cover this scenario: rst_n pulsed low mid-RUN -> out_valid, busy and out_state are 0 immediately (async); in_ready=1 on the next edge; the next block completes correctly.
REQ-039 SHALL cover this scenario: in_inv toggled during RUN -> the result matches the mode latched at acceptance.

Source files
------------

// File: rtl/mix_pkg.sv
// Shared constants, FSM state type and GF(2^8) helper for the MixColumns engine.
package mix_pkg;

  localparam int STATE_W  = 128;
  localparam int COL_W    = 32;
  localparam int BYTE_W   = 8;
  localparam int NUM_COLS = 4;

  localparam logic [BYTE_W-1:0] GF_POLY = 8'h1b;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Multiply by x in GF(2^8), reducing by x^8+x^4+x^3+x+1.
  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
    return {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Combinational transform of one AES column; inv selects InvMixColumns.
module mix_column_unit
  import mix_pkg::*;
(
  input  logic [COL_W-1:0] col_in,
  input  logic             inv,
  output logic [COL_W-1:0] col_out
);

  logic [BYTE_W-1:0] a  [NUM_COLS];
  logic [BYTE_W-1:0] x2 [NUM_COLS];
  logic [BYTE_W-1:0] x4 [NUM_COLS];
  logic [BYTE_W-1:0] x8 [NUM_COLS];
  logic [BYTE_W-1:0] fwd_b;
  logic [BYTE_W-1:0] inv_b;

  // x2 feeds both modes; x4/x8 extend the same chain for the inverse coefficients.
  always_comb begin
    fwd_b   = '0;
    inv_b   = '0;
    col_out = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      a[i]  = col_in[COL_W-1-BYTE_W*i -: BYTE_W];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
    for (int r = 0; r < NUM_COLS; r++) begin
      // forward row r: 02*a[r] ^ 03*a[r+1] ^ a[r+2] ^ a[r+3]
      fwd_b = x2[r] ^ x2[(r+1)%4] ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
      // inverse row r: 0e*a[r] ^ 0b*a[r+1] ^ 0d*a[r+2] ^ 09*a[r+3]
      inv_b = (x8[r] ^ x4[r] ^ x2[r])
            ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
            ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
            ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
      col_out[COL_W-1-BYTE_W*r -: BYTE_W] = inv ? inv_b : fwd_b;
    end
  end

endmodule

// File: rtl/mix_columns_engine.sv
// Iterative AES (Inv)MixColumns engine: one working register, COLS_PER_CYCLE columns per RUN cycle.
module mix_columns_engine
  import mix_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  input  logic               in_inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic               busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
    $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  state_e                           state_q, state_d;
  logic [1:0]                       col_idx_q;
  logic [NUM_COLS-1:0][COL_W-1:0]   work_p0;
  logic                             mode_q;
  logic                             init_q;
  logic                             accept;
  logic [2:0]                       idx_sum;
  logic                             last_col;

  logic [1:0]       col_sel  [COLS_PER_CYCLE];
  logic [COL_W-1:0] unit_in  [COLS_PER_CYCLE];
  logic [COL_W-1:0] unit_out [COLS_PER_CYCLE];

  // Wider sum so the wrap past column 3 marks the final RUN cycle for every width.
  assign idx_sum  = {1'b0, col_idx_q} + 3'(COLS_PER_CYCLE);
  assign last_col = idx_sum[2];

  // init_q keeps in_ready low until the first edge after reset release.
  assign in_ready  = init_q && ((state_q == ST_IDLE) ||
                                ((state_q == ST_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_state = work_p0;

  // Column c lives in work_p0[3-c], i.e. index ~c for a 2-bit column number.
  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_unit
    assign col_sel[k] = col_idx_q + 2'(k);
    assign unit_in[k] = work_p0[~col_sel[k]];

    mix_column_unit u_col (
      .col_in  (unit_in[k]),
      .inv     (mode_q),
      .col_out (unit_out[k])
    );
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept)   state_d = ST_RUN;
      ST_RUN:  if (last_col) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = accept ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- stage p0: working register, mode and column pointer ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      col_idx_q <= 2'd0;
      work_p0   <= '0;
      mode_q    <= 1'b0;
      init_q    <= 1'b0;
    end else begin
      init_q  <= 1'b1;
      state_q <= state_d;
      if (accept) begin
        work_p0   <= in_state;
        mode_q    <= in_inv;
        col_idx_q <= 2'd0;
      end else if (state_q == ST_RUN) begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
          work_p0[~col_sel[k]] <= unit_out[k];
        end
        col_idx_q <= idx_sum[1:0];
      end
    end
  end

endmodule

// File: tb/tb_mix_columns_engine.sv
// Bench for mix_columns_engine: three instances (1, 2, 4 columns/cycle), vector table plus corner sequences.
module tb_mix_columns_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_state  [3];
  logic         in_inv    [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_state [3];
  logic         busy      [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int C = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    mix_columns_engine #(.COLS_PER_CYCLE(C)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state[g]),
      .in_inv    (in_inv[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g]),
      .busy      (busy[g])
    );
  end

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] sb0[$];
  logic [127:0] sb1[$];
  logic [127:0] sb2[$];

  typedef struct {
    logic         inv;
    logic [127:0] st;
    logic [127:0] exp;
  } vec_t;
  vec_t tbl[5];

  function automatic int cpc(int d);
    return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] model_col(logic [31:0] c, logic inv);
    logic [7:0] coef [4];
    logic [7:0] b [4];
    logic [31:0] r = '0;
    logic [7:0] acc;
    if (inv) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    for (int j = 0; j < 4; j++) b[j] = c[31-8*j -: 8];
    for (int i = 0; i < 4; i++) begin
      acc = 8'h00;
      for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j - i + 4) % 4], b[j]);
      r[31-8*i -: 8] = acc;
    end
    return r;
  endfunction

  function automatic logic [127:0] model_state(logic [127:0] s, logic inv);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[127-32*c -: 32] = model_col(s[127-32*c -: 32], inv);
    return r;
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_push(int d, logic [127:0] v);
    case (d)
      0: sb0.push_back(v);
      1: sb1.push_back(v);
      default: sb2.push_back(v);
    endcase
  endtask

  task automatic sb_pop(int d, output logic [127:0] v, output logic ok);
    ok = 1'b0;
    v  = '0;
    case (d)
      0: if (sb0.size() > 0) begin v = sb0.pop_front(); ok = 1'b1; end
      1: if (sb1.size() > 0) begin v = sb1.pop_front(); ok = 1'b1; end
      default: if (sb2.size() > 0) begin v = sb2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // Output monitor: every completed handshake is checked against the scoreboard.
  always @(negedge clk) begin
    logic [127:0] e;
    logic ok;
    if (rst_n) begin
      for (int d = 0; d < 3; d++) begin
        if (out_valid[d] && out_ready[d]) begin
          sb_pop(d, e, ok);
          if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_out dut%0d: got %h expected no output", d, out_state[d]);
          end else begin
            check($sformatf("data_dut%0d", d), out_state[d], e);
          end
        end
      end
    end
  end

  // Drive a block and return 1 time unit after the accepting edge.
  task automatic send(int d, logic [127:0] st, logic inv, logic [127:0] exp);
    int n;
    n = 0;
    in_state[d] = st;
    in_inv[d]   = inv;
    in_valid[d] = 1'b1;
    @(negedge clk);
    while (!in_ready[d] && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready[d]) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout dut%0d: got in_ready=0 expected 1", d);
      in_valid[d] = 1'b0;
      return;
    end
    sb_push(d, exp);
    @(posedge clk);
    #1 in_valid[d] = 1'b0;
  endtask

  task automatic wait_out(int d, string name);
    int n;
    n = 0;
    while (!out_valid[d] && n < 10) begin
      @(posedge clk);
      #1 n++;
    end
    check($sformatf("%s_latency_dut%0d", name, d), 128'(n), 128'(4 / cpc(d)));
  endtask

  task automatic run_block(int d, logic [127:0] st, logic inv, logic [127:0] exp, string name);
    send(d, st, inv, exp);
    wait_out(d, name);
    @(posedge clk);
    #1;
  endtask

  task automatic b2b(int d, logic [127:0] a_st, logic [127:0] a_exp,
                     logic [127:0] b_st, logic [127:0] b_exp);
    int n;
    send(d, a_st, 1'b0, a_exp);
    in_state[d] = b_st;
    in_inv[d]   = 1'b0;
    in_valid[d] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready[d] && n < 20) begin
      n++;
      @(negedge clk);
    end
    check($sformatf("b2b_accept_in_done_dut%0d", d), 128'(out_valid[d]), 128'(1));
    sb_push(d, b_exp);
    @(posedge clk);
    #1 in_valid[d] = 1'b0;
    n = 0;
    while (!out_valid[d] && n < 10) begin
      check($sformatf("b2b_busy_dut%0d", d), 128'(busy[d]), 128'(1));
      @(posedge clk);
      #1 n++;
    end
    check($sformatf("b2b_latency_dut%0d", d), 128'(n), 128'(4 / cpc(d)));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(string name);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_out_valid_dut%0d", name, d), 128'(out_valid[d]), 128'(0));
      check($sformatf("%s_busy_dut%0d", name, d), 128'(busy[d]), 128'(0));
      check($sformatf("%s_out_state_dut%0d", name, d), out_state[d], 128'h0);
      check($sformatf("%s_in_ready_dut%0d", name, d), 128'(in_ready[d]), 128'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] st, snap;
    logic inv;
    int n;

    tbl[0] = '{1'b0, {4{32'hdb135345}}, {4{32'h8e4da1bc}}};
    tbl[1] = '{1'b1, {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hd5d5d7d6},
                     {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hd4d4d4d5}};
    tbl[2] = '{1'b0, {32'hc6c6c6c6, 32'h2d26314c, 32'hf20a225c, 32'h01010101},
                     {32'hc6c6c6c6, 32'h4d7ebdf8, 32'h9fdc589d, 32'h01010101}};
    tbl[3] = '{1'b0, {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hd4d4d4d5},
                     {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hd5d5d7d6}};
    tbl[4] = '{1'b1, {32'hc6c6c6c6, 32'h4d7ebdf8, 32'h9fdc589d, 32'h01010101},
                     {32'hc6c6c6c6, 32'h2d26314c, 32'hf20a225c, 32'h01010101}};

    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      in_state[d]  = '0;
      in_inv[d]    = 1'b0;
      out_ready[d] = 1'b1;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_t0");
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("in_ready_before_edge", 128'(in_ready[0]), 128'(0));
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++)
      check($sformatf("in_ready_after_reset_dut%0d", d), 128'(in_ready[d]), 128'(1));

    // vector table on every width
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 5; i++)
        run_block(d, tbl[i].st, tbl[i].inv, tbl[i].exp, $sformatf("tbl%0d", i));

    // random blocks checked against the reference model
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 4; i++) begin
        st  = {$urandom, $urandom, $urandom, $urandom};
        inv = 1'($urandom_range(0, 1));
        run_block(d, st, inv, model_state(st, inv), "rand");
      end

    // stall in DONE with out_ready low: output stable, in_valid ignored
    out_ready[1] = 1'b0;
    send(1, tbl[2].st, 1'b0, tbl[2].exp);
    wait_out(1, "stall");
    snap = out_state[1];
    in_valid[1] = 1'b1;
    in_state[1] = {4{32'h01234567}};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_out_state", out_state[1], snap);
      check("stall_out_valid", 128'(out_valid[1]), 128'(1));
      check("stall_in_ready", 128'(in_ready[1]), 128'(0));
    end
    @(posedge clk);
    #1 in_valid[1] = 1'b0;
    out_ready[1] = 1'b1;
    @(posedge clk);
    #1 check("stall_release_busy", 128'(busy[1]), 128'(0));

    // back-to-back blocks with no idle cycle
    b2b(0, tbl[0].st, tbl[0].exp, tbl[2].st, tbl[2].exp);
    b2b(2, tbl[3].st, tbl[3].exp, tbl[0].st, tbl[0].exp);

    // mode and inputs changing during RUN have no effect
    send(0, tbl[3].st, 1'b0, tbl[3].exp);
    n = 0;
    while (!out_valid[0] && n < 10) begin
      in_inv[0]   = ~in_inv[0];
      in_state[0] = {$urandom, $urandom, $urandom, $urandom};
      in_valid[0] = (n < 2);
      @(posedge clk);
      #1 n++;
    end
    in_valid[0] = 1'b0;
    in_inv[0]   = 1'b0;
    check("mode_latch_latency", 128'(n), 128'(4));
    @(posedge clk);
    #1;

    // reset asserted mid-RUN discards the block
    send(0, tbl[0].st, 1'b0, tbl[0].exp);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrun_reset");
    sb0.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("midrun_in_ready_before_edge", 128'(in_ready[0]), 128'(0));
    @(posedge clk);
    #1 check("midrun_in_ready_after_edge", 128'(in_ready[0]), 128'(1));
    run_block(0, tbl[3].st, 1'b0, tbl[3].exp, "post_reset");

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty_dut0", 128'(sb0.size()), 128'(0));
    check("sb_empty_dut1", 128'(sb1.size()), 128'(0));
    check("sb_empty_dut2", 128'(sb2.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
